// File: rtl/forward_ctrl.sv
// Operand forwarding and interlock control for a six-stage in-flight pipe.
// Tracks destination registers from E through M5 and selects bypass sources.
module forward_ctrl (
   input  logic       clk,
   input  logic       rstn,
   input  logic       dec_valid,
   input  logic [5:0] dec_rd,
   input  logic       dec_regwrite,
   input  logic [2:0] dec_lat,
   input  logic [5:0] src0,
   input  logic [5:0] src1,
   input  logic [5:0] src2,
   input  logic [5:0] src3,
   input  logic [5:0] src4,
   input  logic [5:0] src5,
   input  logic       use0,
   input  logic       use1,
   input  logic       use2,
   input  logic       use3,
   input  logic       use4,
   input  logic       use5,
   input  logic       hold,
   input  logic       flush,
   output logic [2:0] forward0,
   output logic [2:0] forward1,
   output logic [2:0] forward2,
   output logic [2:0] forward3,
   output logic [2:0] forward4,
   output logic [2:0] forward5,
   output logic       stall
);

   logic [5:0] src [6];
   logic [5:0] use_v;
   logic [2:0] fwd [6];
   logic [5:0] wait_v;
   logic       hit;

   logic [6:1] vld_q, vld_d;
   logic [5:0] rd_q  [1:6];
   logic [5:0] rd_d  [1:6];
   logic [2:0] lat_q [1:6];
   logic [2:0] lat_d [1:6];

   assign src[0] = src0;
   assign src[1] = src1;
   assign src[2] = src2;
   assign src[3] = src3;
   assign src[4] = src4;
   assign src[5] = src5;
   assign use_v  = {use5, use4, use3, use2, use1, use0};

   // Youngest match decides; an older ready copy never overrides it.
   always_comb begin
      hit = 1'b0;
      for (int n = 0; n < 6; n++) begin
         fwd[n]    = 3'd0;
         wait_v[n] = 1'b0;
         hit       = 1'b0;
         for (int k = 1; k <= 6; k++) begin
            if (!hit && vld_q[k] && rd_q[k] == src[n]) begin
               hit = 1'b1;
               if (3'(k) >= lat_q[k])
                  fwd[n] = 3'(k);
               else
                  wait_v[n] = 1'b1;
            end
         end
         if (!use_v[n] || src[n] == 6'd0) begin
            fwd[n]    = 3'd0;
            wait_v[n] = 1'b0;
         end
      end
   end

   assign forward0 = fwd[0];
   assign forward1 = fwd[1];
   assign forward2 = fwd[2];
   assign forward3 = fwd[3];
   assign forward4 = fwd[4];
   assign forward5 = fwd[5];

   assign stall = dec_valid & ~flush & (|wait_v);

   // Older stages keep advancing during a stall; E receives a bubble.
   always_comb begin
      vld_d = vld_q;
      rd_d  = rd_q;
      lat_d = lat_q;
      if (!hold) begin
         for (int k = 6; k >= 2; k--) begin
            vld_d[k] = vld_q[k-1];
            rd_d[k]  = rd_q[k-1];
            lat_d[k] = lat_q[k-1];
         end
         vld_d[1] = dec_valid & dec_regwrite & ~stall & ~flush
                  & (dec_rd != 6'd0);
         rd_d[1]  = dec_rd;
         lat_d[1] = dec_lat;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_q <= '0;
         for (int k = 1; k <= 6; k++) begin
            rd_q[k]  <= '0;
            lat_q[k] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int k = 1; k <= 6; k++) begin
            rd_q[k]  <= rd_d[k];
            lat_q[k] <= lat_d[k];
         end
      end
   end

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed bench for forward_ctrl: bypass selection, interlocks,
// shadowing, hold/flush, aging and asynchronous reset.
module tb_forward_ctrl;

   logic       clk = 1'b0;
   logic       rstn;
   logic       dec_valid;
   logic [5:0] dec_rd;
   logic       dec_regwrite;
   logic [2:0] dec_lat;
   logic [5:0] src [6];
   logic       use_ [6];
   logic       hold;
   logic       flush;
   logic [2:0] fw [6];
   logic       stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   forward_ctrl dut (
      .clk(clk), .rstn(rstn),
      .dec_valid(dec_valid), .dec_rd(dec_rd),
      .dec_regwrite(dec_regwrite), .dec_lat(dec_lat),
      .src0(src[0]), .src1(src[1]), .src2(src[2]),
      .src3(src[3]), .src4(src[4]), .src5(src[5]),
      .use0(use_[0]), .use1(use_[1]), .use2(use_[2]),
      .use3(use_[3]), .use4(use_[4]), .use5(use_[5]),
      .hold(hold), .flush(flush),
      .forward0(fw[0]), .forward1(fw[1]), .forward2(fw[2]),
      .forward3(fw[3]), .forward4(fw[4]), .forward5(fw[5]),
      .stall(stall)
   );

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      dec_valid    = 1'b0;
      dec_rd       = '0;
      dec_regwrite = 1'b0;
      dec_lat      = 3'd1;
      hold         = 1'b0;
      flush        = 1'b0;
      for (int i = 0; i < 6; i++) begin
         src[i]  = '0;
         use_[i] = 1'b0;
      end
   endtask

   task automatic issue(input logic [5:0] rd, input logic [2:0] lat);
      clr();
      dec_valid    = 1'b1;
      dec_regwrite = 1'b1;
      dec_rd       = rd;
      dec_lat      = lat;
   endtask

   task automatic consume(input int n, input logic [5:0] r);
      clr();
      dec_valid = 1'b1;
      src[n]    = r;
      use_[n]   = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle();
      clr();
      repeat (7) tick();
   endtask

   initial begin
      clr();
      rstn = 1'b0;
      src[0] = 6'd5; use_[0] = 1'b1; dec_valid = 1'b1;
      mid();
      chk("rst_fw0", 8'(fw[0]), 8'd0);
      chk("rst_stall", 8'(stall), 8'd0);
      tick();
      rstn = 1'b1;
      mid();
      chk("post_rst_fw0", 8'(fw[0]), 8'd0);
      tick();

      // ALU back-to-back
      issue(6'd5, 3'd1);
      mid(); chk("alu_issue_stall", 8'(stall), 8'd0);
      tick();
      consume(0, 6'd5);
      mid();
      chk("alu_fw0", 8'(fw[0]), 8'd1);
      chk("alu_stall", 8'(stall), 8'd0);
      tick();
      idle();

      // Load-use interlock
      issue(6'd7, 3'd3);
      tick();
      consume(1, 6'd7);
      mid();
      chk("lu_stall_c1", 8'(stall), 8'd1);
      chk("lu_fw1_c1", 8'(fw[1]), 8'd0);
      tick();
      mid(); chk("lu_stall_c2", 8'(stall), 8'd1);
      tick();
      mid();
      chk("lu_fw1_c3", 8'(fw[1]), 8'd3);
      chk("lu_stall_c3", 8'(stall), 8'd0);
      tick();
      idle();

      // Shadowing: younger not-ready match wins
      issue(6'd9, 3'd1);
      tick();
      issue(6'd9, 3'd2);
      tick();
      consume(2, 6'd9);
      mid();
      chk("sh_stall", 8'(stall), 8'd1);
      chk("sh_fw2_wait", 8'(fw[2]), 8'd0);
      tick();
      mid();
      chk("sh_fw2", 8'(fw[2]), 8'd2);
      chk("sh_stall_off", 8'(stall), 8'd0);
      tick();
      idle();

      // Register 0 and unused sources
      issue(6'd0, 3'd1);
      tick();
      issue(6'd4, 3'd1);
      tick();
      clr();
      dec_valid = 1'b1;
      src[0] = 6'd0; use_[0] = 1'b1;
      src[3] = 6'd4; use_[3] = 1'b0;
      src[4] = 6'd4; use_[4] = 1'b1;
      mid();
      chk("r0_fw0", 8'(fw[0]), 8'd0);
      chk("unused_fw3", 8'(fw[3]), 8'd0);
      chk("used_fw4", 8'(fw[4]), 8'd1);
      chk("r0_stall", 8'(stall), 8'd0);
      tick();
      idle();

      // FP f0 (reg 32) tracked
      issue(6'd32, 3'd1);
      tick();
      consume(5, 6'd32);
      mid(); chk("f0_fw5", 8'(fw[5]), 8'd1);
      tick();
      idle();

      // Hold freezes the pipe
      issue(6'd12, 3'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         consume(0, 6'd12);
         dec_valid = 1'b0;
         hold = 1'b1;
         mid(); chk("hold_fw0", 8'(fw[0]), 8'd1);
         tick();
      end
      consume(0, 6'd12);
      dec_valid = 1'b0;
      mid(); chk("unhold_fw0", 8'(fw[0]), 8'd1);
      tick();
      mid(); chk("unhold_fw0_m", 8'(fw[0]), 8'd2);
      tick();

      // Hold and flush together: hold wins, E entry unchanged
      issue(6'd14, 3'd1);
      tick();
      issue(6'd15, 3'd1);
      hold = 1'b1;
      flush = 1'b1;
      tick();
      consume(0, 6'd14);
      dec_valid = 1'b0;
      mid(); chk("hf_fw0", 8'(fw[0]), 8'd1);
      tick();

      // Flush suppresses the new entry
      issue(6'd13, 3'd1);
      flush = 1'b1;
      mid(); chk("fl_stall", 8'(stall), 8'd0);
      tick();
      consume(1, 6'd13);
      mid(); chk("fl_fw1", 8'(fw[1]), 8'd0);
      tick();
      idle();

      // Aging through all six stages
      issue(6'd20, 3'd1);
      tick();
      for (int i = 1; i <= 6; i++) begin
         consume(0, 6'd20);
         dec_valid = 1'b0;
         mid(); chk($sformatf("age_%0d", i), 8'(fw[0]), 8'(i));
         tick();
      end
      consume(0, 6'd20);
      mid(); chk("age_out", 8'(fw[0]), 8'd0);
      tick();

      // Reset mid-aging
      issue(6'd20, 3'd1);
      tick();
      consume(0, 6'd20);
      dec_valid = 1'b0;
      mid(); chk("ar_fw0", 8'(fw[0]), 8'd1);
      rstn = 1'b0;
      #1;
      chk("ar_fw0_rst", 8'(fw[0]), 8'd0);
      tick();
      rstn = 1'b1;
      mid(); chk("ar_fw0_after", 8'(fw[0]), 8'd0);
      tick();

      // Reset mid-stall
      issue(6'd7, 3'd6);
      tick();
      consume(1, 6'd7);
      mid(); chk("rs_stall", 8'(stall), 8'd1);
      rstn = 1'b0;
      #1;
      chk("rs_stall_rst", 8'(stall), 8'd0);
      tick();
      rstn = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got 1 exp 0");
      $fatal(1);
   end

endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rstn  in  1  reset, asynchronous, active-low.
REQ-003 dec_valid  in  1  decode slot holds a valid instruction this cycle.
REQ-004 dec_rd  in  6  destination register of decode instruction ({rdflag, rd[4:0]}).
REQ-005 dec_regwrite  in  1  decode instruction writes dec_rd.
REQ-006 dec_lat  in  3  stage at which the result becomes available: 1=E, 2=M, 3=M2, 4=M3, 5=M4, 6=M5; 0 and 7 are illegal.
REQ-007 src0..src5  in  6 each  source register numbers (rs0, rs1, reg2..reg5).
REQ-008 use0..use5  in  1 each  corresponding source is actually read.
REQ-009 hold  in  1  global freeze (memory/IO stall).
REQ-010 flush  in  1  kill the decode instruction (mispredict).
REQ-011 forward0..forward5  out  3 each  operand select: 0=register file, 1=E, 2=M, 3=M2, 4=M3, 5=M4, 6=M5.
REQ-012 stall  out  1  decode must not advance; a bubble enters E.

Function
REQ-013 State: six-entry in-flight shift pipe, stages E,M,M2,M3,M4,M5 (index 1..6); each entry holds valid, rd[5:0], lat[2:0].
REQ-014 Entry at stage k is ready iff valid and k >= lat.
REQ-015 forwardN, combinational: if !useN or srcN==0, then 0; else the lowest-index (youngest) valid stage with rd==srcN; if that entry is ready, its index; otherwise 0.
REQ-016 Match search stops at the youngest match; an older ready match never overrides a younger not-ready one.
REQ-017 stall = dec_valid & !flush & OR over N of (useN & srcN!=0 & youngest match exists & not ready).
REQ-018 forwardN never equals 7; a value of 7 is a design error.
REQ-019 Advance (rising edge, hold=0): M5 entry discarded; each stage k receives stage k-1 (k=2..6).
REQ-020 New E entry on advance: valid = dec_valid & dec_regwrite & !stall & !flush & dec_rd!=0; rd=dec_rd; lat=dec_lat.
REQ-021 hold=1: all entries keep their values; forward/stall still evaluate combinationally on the held state.
REQ-022 hold=1 and flush=1 together: hold wins; flush is reevaluated on the next non-hold cycle by the upstream pipeline.
REQ-023 Stall cycles insert a bubble (valid=0) into E while older stages still advance; stall therefore deasserts once the producer reaches its lat stage.
REQ-024 Two in-flight entries with the same rd: the younger shadows the older per REQ-016.
REQ-025 Register 0 ({0,00000}) is never tracked or forwarded; register 32 ({1,00000}, FP f0) is tracked normally.
REQ-026 Worst-case stall length is 5 cycles (dec_lat=6 producer immediately followed by a consumer).
REQ-027 No combinational path from forwardN/stall back into the state except through the clock edge.

Reset
REQ-028 rstn low: all entry valid bits cleared to 0 immediately; rd and lat cleared to 0.
REQ-029 While reset is held and after release: forward0..5=0 and stall=0 until a writing instruction is accepted.
REQ-030 Reset asserted mid-stall: stall drops asynchronously with the cleared state; no pending entry survives.

Verification
REQ-031 ALU back-to-back: cycle 0 accept rd=5, lat=1; cycle 1 src0=5, use0=1 -> forward0=1, stall=0.
REQ-032 Load-use: cycle 0 accept rd=7, lat=3; cycle 1 src1=7 -> stall=1 for cycles 1-2; cycle 3 forward1=3, stall=0; E holds bubbles in cycles 2-3.
REQ-033 Shadowing: accept rd=9 lat=1, then rd=9 lat=2, then consumer src2=9 -> stall=1 one cycle, then forward2=2 (not 3).
REQ-034 Register 0 and unused: src0=0, use0=1 with an in-flight rd=0 write -> forward0=0; src3=4, use3=0 with rd=4 in E -> forward3=0, stall=0.
REQ-035 Hold/flush: rd=12 in E, hold=1 for 3 cycles -> forward for src=12 stays 1 and E is unchanged; flush=1 with dec_rd=13 -> no entry for 13 is created and forward for src=13 is 0 next cycle.
REQ-036 Aging/reset: rd=20 lat=1 accepted -> forward for src=20 reads 1,2,3,4,5,6 over 6 cycles, then 0; asserting rstn=0 mid-sequence -> forward=0 at once.
